// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter (8N1) fed by a byte FIFO
// Ports: clk24 clock, rst async active-high reset; memory_address / memory_write_value /
// memory_write_sections bus write side; read_value / read_hit registered read port; tx serial line.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDRESS = 32'h80000010,
  parameter int CLKS_PER_BIT = 208,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk24,
  input  logic        rst,
  input  logic [31:0] memory_address,
  input  logic [31:0] memory_write_value,
  input  logic [2:0]  memory_write_sections,
  output logic [31:0] read_value,
  output logic        read_hit,
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] STATUS_ADDRESS = BASE_ADDRESS + 32'd4;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state, w_state_nxt;
  logic [7:0] r_fifo [FIFO_DEPTH];
  logic [AW:0] r_wr_ptr, r_rd_ptr, w_count;
  logic [BW-1:0] r_baud, w_baud_nxt;
  logic [2:0] r_bit, w_bit_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [31:0] r_read_value, w_status;
  logic [3:0] w_cnt4;
  logic r_read_hit, r_ovf, r_tx, w_tx_nxt, w_pop, w_push, w_full, w_empty;
  logic w_data_sel, w_stat_sel, w_data_wr, w_clr, w_baud_end, w_unused;
  assign w_unused = &{1'b0, memory_address[1:0], memory_write_value[31:8], memory_write_sections[2:1]};
  assign w_data_sel = memory_address[31:2] == BASE_ADDRESS[31:2];
  assign w_stat_sel = memory_address[31:2] == STATUS_ADDRESS[31:2];
  assign w_data_wr = w_data_sel & memory_write_sections[0];
  assign w_clr = w_stat_sel & memory_write_sections[0] & memory_write_value[2];
  // Pointer MSB separates full from empty; fullness is taken before any same-cycle pop.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign w_empty = r_wr_ptr == r_rd_ptr;
  assign w_full = w_count == DEPTH;
  assign w_push = w_data_wr & ~w_full;
  assign w_cnt4 = (32'(w_count) > 32'd15) ? 4'hF : 4'(w_count);
  assign w_status = {24'h0, w_cnt4, w_empty, r_ovf, r_state != IDLE, w_full};
  assign w_baud_end = r_baud == BAUD_LAST;
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt = (r_state == IDLE || w_baud_end) ? '0 : r_baud + 1'b1;
    w_bit_nxt = r_bit;
    w_shift_nxt = r_shift;
    w_pop = 1'b0;
    case (r_state)
      IDLE: if (!w_empty) begin
        w_pop = 1'b1;
        w_shift_nxt = r_fifo[r_rd_ptr[AW-1:0]];
        w_bit_nxt = '0;
        w_state_nxt = START;
      end
      START: if (w_baud_end) w_state_nxt = DATA;
      DATA: if (w_baud_end) begin
        w_shift_nxt = r_shift >> 1;
        w_bit_nxt = r_bit + 1'b1;
        w_state_nxt = (r_bit == 3'd7) ? STOP : DATA;
      end
      STOP: if (w_baud_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    // tx is registered from the next-state view so the line lines up with the state it belongs to.
    w_tx_nxt = (w_state_nxt == START) ? 1'b0 : (w_state_nxt == DATA) ? w_shift_nxt[0] : 1'b1;
  end
  always_ff @(posedge clk24 or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_baud <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_tx <= 1'b1;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf <= 1'b0;
      r_read_value <= '0;
      r_read_hit <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud <= w_baud_nxt;
      r_bit <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_tx <= w_tx_nxt;
      r_wr_ptr <= r_wr_ptr + (AW+1)'(w_push);
      r_rd_ptr <= r_rd_ptr + (AW+1)'(w_pop);
      r_ovf <= (w_data_wr & w_full) ? 1'b1 : w_clr ? 1'b0 : r_ovf;
      r_read_value <= w_stat_sel ? w_status : '0;
      r_read_hit <= w_data_sel | w_stat_sel;
    end
  always_ff @(posedge clk24)
    if (w_push) r_fifo[r_wr_ptr[AW-1:0]] <= memory_write_value[7:0];
  assign read_value = r_read_value;
  assign read_hit = r_read_hit;
  assign tx = r_tx;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: randomized and directed checks of uart_tx_mmio against a frame-level model
module tb_uart_tx_mmio;
  localparam int CPB = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] DATA_A = 32'h80000010;
  localparam logic [31:0] STAT_A = 32'h80000014;
  logic clk24 = 1'b0;
  logic rst = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0] sec = '0;
  logic [31:0] read_value;
  logic read_hit, tx;
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q[$];
  logic [7:0] cur = '0;
  int busy_left = 0;
  logic ovf = 1'b0;
  logic [31:0] exp_rv = '0;
  logic exp_rh = 1'b0;
  logic [9:0] pat = 10'b1_10100101_0;
  uart_tx_mmio #(.BASE_ADDRESS(DATA_A), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk24(clk24), .rst(rst), .memory_address(addr), .memory_write_value(wdata),
    .memory_write_sections(sec), .read_value(read_value), .read_hit(read_hit), .tx(tx));
  always #5 clk24 = ~clk24;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // Expected line level from position inside the current frame: start, 8 data bits LSB first, stop.
  function automatic logic exp_tx();
    int p = FRAME - busy_left;
    if (busy_left == 0) return 1'b1;
    if (p < CPB) return 1'b0;
    if (p < 9 * CPB) return cur[(p - CPB) / CPB];
    return 1'b1;
  endfunction
  task automatic tick();
    logic full, dw;
    @(posedge clk24);
    full = q.size() == DEPTH;
    dw = addr[31:2] == DATA_A[31:2] && sec[0];
    if (rst) begin
      exp_rh = 1'b0;
      exp_rv = '0;
      q.delete();
      busy_left = 0;
      ovf = 1'b0;
    end else begin
      exp_rh = addr[31:2] == DATA_A[31:2] || addr[31:2] == STAT_A[31:2];
      exp_rv = (addr[31:2] == STAT_A[31:2]) ?
        {24'h0, 4'(q.size()), q.size() == 0, ovf, busy_left > 0, full} : 32'h0;
      if (busy_left > 0) busy_left--;
      else if (q.size() > 0) begin
        cur = q.pop_front();
        busy_left = FRAME;
      end
      if (dw) begin
        if (full) ovf = 1'b1;
        else q.push_back(wdata[7:0]);
      end else if (addr[31:2] == STAT_A[31:2] && sec[0] && wdata[2]) ovf = 1'b0;
    end
    @(negedge clk24);
    check("read_hit", read_hit, exp_rh);
    check("read_value", read_value, exp_rv);
    check("tx", tx, exp_tx());
  endtask
  task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    addr = a;
    wdata = d;
    sec = s;
    tick();
    addr = '0;
    wdata = '0;
    sec = '0;
  endtask
  initial begin
    tick();
    check("reset_tx", tx, 1);
    check("reset_rv", read_value, 0);
    rst = 1'b0;
    bus(STAT_A, 0, 0);
    check("status_after_reset", read_value, 32'h8);
    check("status_hit", read_hit, 1);
    bus(32'h00000100, 0, 0);
    check("other_hit", read_hit, 0);
    check("other_rv", read_value, 0);
    bus(DATA_A, 0, 0);
    check("data_read_hit", read_hit, 1);
    bus(DATA_A, 32'hA5, 3'b001);
    addr = STAT_A;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      check("a5_frame", tx, pat[i / CPB]);
      if (i > 0) check("a5_busy", read_value[1], 1);
    end
    addr = '0;
    tick();
    check("a5_idle", tx, 1);
    for (int i = 0; i < 6; i++) bus(DATA_A, 32'h11 * (i + 1), 3'b001);
    bus(STAT_A, 0, 0);
    check("ovf_status", read_value, 32'h47);
    repeat (6 * (FRAME + 1)) tick();
    bus(STAT_A, 32'h4, 3'b001);
    bus(STAT_A, 0, 0);
    check("ovf_cleared", read_value[2], 0);
    bus(DATA_A, 32'h01, 3'b001);
    bus(DATA_A, 32'h02, 3'b001);
    bus(DATA_A, 32'h03, 3'b110);
    bus(STAT_A, 0, 0);
    check("lane_count", read_value[7:4], 1);
    repeat (3 * (FRAME + 1)) tick();
    bus(DATA_A, 32'hA5, 3'b001);
    bus(DATA_A, 32'h81, 3'b001);
    bus(DATA_A, 32'h7E, 3'b001);
    for (int i = 0; i < 60 && FRAME - busy_left < 4 * CPB + 1; i++) tick();
    check("bit3_low", tx, 0);
    rst = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    tick();
    rst = 1'b0;
    bus(STAT_A, 0, 0);
    check("status_after_midrst", read_value, 32'h8);
    bus(DATA_A, 32'h5A, 3'b001);
    tick();
    check("fresh_start", tx, 0);
    repeat (FRAME + 2) tick();
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 9);
      if (r < 5) bus(DATA_A, $urandom, 3'($urandom_range(0, 7)));
      else if (r == 5) bus(STAT_A, $urandom, 3'($urandom_range(0, 7)));
      else if (r < 8) bus(STAT_A, 0, 0);
      else if (r == 8) bus($urandom, $urandom, 3'($urandom_range(0, 7)));
      else repeat ($urandom_range(1, 50)) tick();
    end
    repeat ((DEPTH + 1) * (FRAME + 1)) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
